// File: rtl/image_buffer_writer_20x20.sv
// Assembles a raster-ordered 9-bit pixel stream into a flattened 20x20 image bus.
// Latency: an accepted pixel is visible on image right after its accept edge; frame_done is registered.
// Backpressure: pix_ready is low outside LOAD and while start is high. Optional macro: IMG_CLEAR_ON_START_EN.
module image_buffer_writer_20x20 #(
  parameter int IMG_W  = 20,
  parameter int IMG_H  = 20,
  parameter int PIX_W  = 9,
  parameter int ADDR_W = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [PIX_W-1:0]               pix_in,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  output logic [ADDR_W-1:0]              address,
  output logic [IMG_W*IMG_H*PIX_W-1:0]   image,
  output logic                           image_valid,
  output logic                           frame_done,
  output logic                           busy
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   accept;
  logic   last_write;
  logic   load_start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake decode; start always wins over a pixel in LOAD
  always_comb begin
    next_state = state;
    pix_ready  = 1'b0;
    accept     = 1'b0;
    last_write = 1'b0;
    load_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        pix_ready  = !start;
        accept     = pix_valid && !start;
        last_write = accept && (address == LAST_ADDR);
        if (start) begin
          load_start = 1'b1;
        end else if (last_write) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          next_state = LOAD;
          load_start = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == LOAD);

  // Write pointer and frame status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address     <= '0;
      image_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= last_write;
      if (load_start) begin
        address     <= '0;
        image_valid <= 1'b0;
      end else if (accept) begin
        if (last_write) begin
          address     <= '0;
          image_valid <= 1'b1;
        end else begin
          address <= address + ADDR_W'(1);
        end
      end
    end
  end

  // Image storage: only the addressed slot changes on a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image <= '0;
    end else begin
`ifdef IMG_CLEAR_ON_START_EN
      if (load_start) begin
        image <= '0;
      end else if (accept) begin
        image[int'(address)*PIX_W +: PIX_W] <= pix_in;
      end
`else
      if (accept) begin
        image[int'(address)*PIX_W +: PIX_W] <= pix_in;
      end
`endif
    end
  end

endmodule

// File: tb/tb_image_buffer_writer_20x20.sv
// Scoreboard bench for image_buffer_writer_20x20: expected frames are queued as they are sent,
// and a monitor compares the image whenever frame_done is presented.
// Directed checks cover reset, restart, DONE hold and asynchronous reset.
module tb_image_buffer_writer_20x20;

  localparam int NPIX = 400;
  localparam int IW   = NPIX * 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [8:0]    pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [8:0]    address;
  logic [IW-1:0] image;
  logic          image_valid;
  logic          frame_done;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int fd_count = 0;
  logic prev_fd = 1'b0;

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] exp_a;
  logic [IW-1:0] exp_b;
  logic [IW-1:0] exp_ones;
  logic [IW-1:0] zero_img;

  image_buffer_writer_20x20 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .address(address), .image(image), .image_valid(image_valid),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      failures++;
      idx = 0;
      for (int i = NPIX - 1; i >= 0; i--)
        if (act[i*9 +: 9] !== exp[i*9 +: 9]) idx = i;
      $display("FAIL %s first_bad_pixel=%0d actual=%0h required=%0h",
               name, idx, act[idx*9 +: 9], exp[idx*9 +: 9]);
    end
  endtask

  // Scoreboard monitor: every frame_done pops one expected frame
  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_done === 1'b1) begin
      fd_count++;
      chk("fd_single_cycle", {31'd0, prev_fd}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fd_unexpected actual=frame_done required=no_frame_pending");
      end else begin
        chk_img("frame_image", image, exp_q.pop_front());
        chk("frame_image_valid", {31'd0, image_valid}, 32'd1);
        chk("frame_address", {23'd0, address}, 32'd0);
        chk("frame_busy", {31'd0, busy}, 32'd0);
      end
    end
    prev_fd = frame_done;
  end

  task automatic send(input logic [8:0] v);
    logic r;
    int   n;
    pix_in    = v;
    pix_valid = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_ready required=ready");
    end
  endtask

  task automatic idle_cycle();
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    zero_img = '0;
    for (int n = 0; n < NPIX; n++) begin
      exp_a[n*9 +: 9]    = 9'(n);
      exp_b[n*9 +: 9]    = 9'(NPIX - 1 - n);
      exp_ones[n*9 +: 9] = 9'h1FF;
    end
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = '0;

    // 1: reset state
    @(negedge clk);
    chk_img("rst_image", image, zero_img);
    chk("rst_address", {23'd0, address}, 32'd0);
    chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("rst_image_valid", {31'd0, image_valid}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_pix_ready", {31'd0, pix_ready}, 32'd0);
    @(posedge clk); #1;

    // 2: back-to-back full frame
    pulse_start();
    @(negedge clk);
    chk("load_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(exp_a);
    for (int n = 0; n < NPIX; n++) send(9'(n));
    idle_cycle();
    idle_cycle();
    chk("t2_fd_count", fd_count, 32'd1);

    // 3: full frame with random idle gaps
    pulse_start();
    exp_q.push_back(exp_a);
    for (int n = 0; n < NPIX; n++) begin
      while ($urandom_range(0, 9) < 3) idle_cycle();
      send(9'(n));
    end
    idle_cycle();
    idle_cycle();
    chk("t3_fd_count", fd_count, 32'd2);

    // 4: restart mid-frame with pix_valid held high
    pulse_start();
    for (int n = 0; n < 150; n++) send(9'h0AA);
    pix_valid = 1'b1; pix_in = 9'h155; start = 1'b1;
    @(negedge clk);
    chk("restart_pix_ready", {31'd0, pix_ready}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("restart_address", {23'd0, address}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(exp_b);
    for (int n = 0; n < NPIX; n++) send(9'(NPIX - 1 - n));
    idle_cycle();
    idle_cycle();
    chk("t4_fd_count", fd_count, 32'd3);

    // 5: pixels offered in DONE are ignored; start reopens the frame
    pix_valid = 1'b1; pix_in = 9'h1FF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_pix_ready", {31'd0, pix_ready}, 32'd0);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    @(negedge clk);
    chk_img("done_image_hold", image, exp_b);
    chk("done_image_valid", {31'd0, image_valid}, 32'd1);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    chk("t5_image_valid", {31'd0, image_valid}, 32'd0);
    chk("t5_pix_ready", {31'd0, pix_ready}, 32'd1);
`ifdef IMG_CLEAR_ON_START_EN
    chk_img("t5_image_after_start", image, zero_img);
`else
    chk_img("t5_image_after_start", image, exp_b);
`endif
    @(posedge clk); #1;

    // 6: all-ones frame, restart behaviour, then asynchronous reset mid-frame
    exp_q.push_back(exp_ones);
    for (int n = 0; n < NPIX; n++) send(9'h1FF);
    idle_cycle();
    idle_cycle();
    chk("t6_fd_count", fd_count, 32'd4);
    pulse_start();
    @(negedge clk);
`ifdef IMG_CLEAR_ON_START_EN
    chk_img("t6_image_after_start", image, zero_img);
`else
    chk_img("t6_image_after_start", image, exp_ones);
`endif
    @(posedge clk); #1;
    for (int n = 0; n < 10; n++) send(9'h033);
    pix_valid = 1'b0;
    @(negedge clk);
    chk("t6_mid_address", {23'd0, address}, 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk_img("async_rst_image", image, zero_img);
    chk("async_rst_address", {23'd0, address}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_image_valid", {31'd0, image_valid}, 32'd0);
    chk("async_rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle_cycle();
    idle_cycle();
    chk("final_fd_count", fd_count, 32'd4);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
